l0_skew_buffer: RTL and testbench

Parametrised row-parallel input buffer feeding the west edge of the MAC array. Each of `row` lanes holds a `bw`-bit FIFO of configurable depth. All lanes are written together as one `row*bw` vector. Reads run in one of two run-time-selectable modes: broadcast, where every lane pops in the same cycle, or diagonal skew, where lane i pops i cycles after lane 0 to form the systolic wavefront. Per-lane valid flags mark the lanes that actually produced data.

---
 rtl/l0_skew_buffer.sv | 180 ++++++++++++++++++
 tb/tb_l0_skew_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_skew_buffer.sv
// ============================================================================
// l0_skew_buffer
// ----------------------------------------------------------------------------
// Row-parallel input buffer that feeds the west edge of the MAC array.
// Each of `row` lanes is a `bw`-bit FIFO with `depth` entries. All lanes are
// written together from one packed vector. Reads use one of two modes:
//   mode 0 (broadcast)     : every lane pops in the same cycle
//   mode 1 (diagonal skew) : lane i pops i cycles after lane 0, forming the
//                            systolic wavefront
//
// Optional feature macro: L0_SKEW_OVF_EN
//   defined   : o_ovf is a sticky flag, set on any edge where wr && o_full,
//               cleared only by reset
//   undefined : o_ovf is tied to 0 and no flag register exists
//
// Ports
//   clk      in   1        clock, all logic on the rising edge
//   reset    in   1        synchronous, active-high
//   wr       in   1        push `in` into all lanes
//   in       in   row*bw   lane i = bits [bw*(i+1)-1 : bw*i]
//   rd       in   1        read request, enters lane 0 read-enable
//   mode     in   1        0 = broadcast, 1 = diagonal skew
//   out      out  row*bw   registered lane data, same packing as `in`
//   o_valid  out  row      lane i `out` was updated at the last edge
//   o_full   out  1        any lane holds `depth` entries
//   o_ready  out  1        ~o_full
//   o_empty  out  1        every lane holds zero entries
//   o_ovf    out  1        sticky write-overflow flag
//
// Handshake: a write is accepted on an edge iff wr && !o_full, evaluated on
// the counts before that edge; a write while full is dropped with no state
// change, even if a lane pops on the same edge. Reads have no back-pressure:
// a read-enable reaching an empty lane is silently ignored (o_valid low, out
// holds its value).
// ============================================================================
module l0_skew_buffer #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [row*bw-1:0] in,
    input  logic              rd,
    input  logic              mode,
    output logic [row*bw-1:0] out,
    output logic [row-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty,
    output logic              o_ovf
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full_count = cw'(depth);

    // ------------------------------------------------------------------------
    // Shared control
    // ------------------------------------------------------------------------
    logic [row-1:0] rd_en;       // registered per-lane read enables
    logic [row-1:0] pop;         // lane pops on this edge
    logic [row-1:0] lane_full;   // lane count == depth
    logic [row-1:0] lane_empty;  // lane count == 0
    logic           push;        // write accepted on this edge

    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign o_empty = &lane_empty;

    // Full is judged on pre-edge counts, so a pop on the same edge never
    // makes room for a write that arrives while full.
    assign push = wr && !o_full;

    // Read-enable vector. Mode is sampled on every edge: broadcast loads the
    // request into every lane, skew shifts it one lane per cycle. Bits that
    // are already in the vector are not cleared when the mode changes; they
    // are consumed by their lane on this edge like any other enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en <= '0;
        end else if (!mode) begin
            rd_en <= {row{rd}};
        end else begin
            rd_en <= {rd_en[row-2:0], rd};
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane FIFO
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < row; i++) begin : g_lane
        logic [bw-1:0] mem [depth];
        logic [aw-1:0] wr_ptr;
        logic [aw-1:0] rd_ptr;
        logic [cw-1:0] count;
        logic [bw-1:0] out_q;
        logic          valid_q;

        assign lane_full[i]  = (count == full_count);
        assign lane_empty[i] = (count == '0);

        // Pop needs data present before the edge: an entry pushed into an
        // empty lane becomes readable one edge later.
        assign pop[i] = rd_en[i] && !lane_empty[i];

        // Storage has no reset; only pointers and counts define contents.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= in[bw*i +: bw];
            end
        end

        // Pointers wrap naturally at aw bits (depth is a power of two).
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop[i]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Output register: updated only on a pop, otherwise holds the last
        // value so an underflowing read leaves the lane untouched.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= pop[i];
                if (pop[i]) begin
                    out_q <= mem[rd_ptr];
                end
            end
        end

        assign out[bw*i +: bw] = out_q;
        assign o_valid[i]      = valid_q;

        // Occupancy invariant: the write pointer always sits `count` entries
        // ahead of the read pointer, modulo depth.
        a_ptr_count : assert property (@(posedge clk) disable iff (reset)
            (rd_ptr + count[aw-1:0]) == wr_ptr);
        a_count_max : assert property (@(posedge clk) disable iff (reset)
            count <= full_count);
    end

    // ------------------------------------------------------------------------
    // Optional sticky overflow flag
    // ------------------------------------------------------------------------
`ifdef L0_SKEW_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr && o_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_l0_skew_buffer.sv
// Bench for l0_skew_buffer: a queue-based lane model with per-lane read
// schedules, checked against the DUT on every falling edge, plus literal
// expectations at hand-computed points.
module tb_l0_skew_buffer;

    localparam int nrow = 8;
    localparam int nbw  = 4;
    localparam int nd   = 64;

`ifdef L0_SKEW_OVF_EN
    localparam bit ovf_en = 1'b1;
`else
    localparam bit ovf_en = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr;
    logic                  rd;
    logic                  mode;
    logic [nrow*nbw-1:0]   in_v;
    logic [nrow*nbw-1:0]   out_v;
    logic [nrow-1:0]       o_valid;
    logic                  o_full;
    logic                  o_ready;
    logic                  o_empty;
    logic                  o_ovf;

    always #5 clk = ~clk;

    l0_skew_buffer #(.row(nrow), .bw(nbw), .depth(nd)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .in      (in_v),
        .rd      (rd),
        .mode    (mode),
        .out     (out_v),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_empty (o_empty),
        .o_ovf   (o_ovf)
    );

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Vector whose lane i carries (a + i) truncated to the lane width.
    function automatic logic [nrow*nbw-1:0] pat(input int a);
        logic [nrow*nbw-1:0] r;
        r = '0;
        for (int i = 0; i < nrow; i++) r[i*nbw +: nbw] = nbw'(a + i);
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: per-lane data queues, per-lane list of cycles at
    // which a read request reaches that lane.
    // ------------------------------------------------------------------------
    logic [nbw-1:0]      dq    [nrow][$];
    int                  sched [nrow][$];
    logic [nrow*nbw-1:0] m_out;
    logic [nrow-1:0]     m_valid;
    logic                m_ovf;
    int                  cyc = 0;

    always @(posedge clk) begin : model
        bit full;
        bit req;
        if (reset) begin
            for (int i = 0; i < nrow; i++) begin
                dq[i].delete();
                sched[i].delete();
            end
            m_out   = '0;
            m_valid = '0;
            m_ovf   = 1'b0;
        end else begin
            full = 1'b0;
            for (int i = 0; i < nrow; i++) if (dq[i].size() == nd) full = 1'b1;
            for (int i = 0; i < nrow; i++) begin
                req = 1'b0;
                while (sched[i].size() > 0 && sched[i][0] <= cyc) begin
                    void'(sched[i].pop_front());
                    req = 1'b1;
                end
                if (req && dq[i].size() > 0) begin
                    m_out[i*nbw +: nbw] = dq[i].pop_front();
                    m_valid[i] = 1'b1;
                end else begin
                    m_valid[i] = 1'b0;
                end
            end
            if (wr && !full)
                for (int i = 0; i < nrow; i++) dq[i].push_back(in_v[i*nbw +: nbw]);
            if (wr && full && ovf_en) m_ovf = 1'b1;
            if (rd)
                for (int i = 0; i < nrow; i++) sched[i].push_back(mode ? cyc + 1 + i : cyc + 1);
        end
        cyc++;
    end

    // ------------------------------------------------------------------------
    // Scoreboard compare, every falling edge once out of the first reset
    // ------------------------------------------------------------------------
    always @(negedge clk) begin : compare
        logic me;
        logic mf;
        if (chk_en) begin
            me = 1'b1;
            mf = 1'b0;
            for (int i = 0; i < nrow; i++) begin
                if (dq[i].size() != 0) me = 1'b0;
                if (dq[i].size() == nd) mf = 1'b1;
            end
            check("cyc_out",     out_v,   m_out);
            check("cyc_o_valid", o_valid, m_valid);
            check("cyc_o_full",  o_full,  mf);
            check("cyc_o_ready", o_ready, !mf);
            check("cyc_o_empty", o_empty, me);
            check("cyc_o_ovf",   o_ovf,   m_ovf);
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write3();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr = 1'b1; in_v = pat(k);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; mode = 1'b0; in_v = '0;
        repeat (2) @(negedge clk);
        check("rst_out",     out_v,   '0);
        check("rst_o_valid", o_valid, '0);
        check("rst_o_empty", o_empty, 1'b1);
        check("rst_o_full",  o_full,  1'b0);
        check("rst_o_ready", o_ready, 1'b1);
        check("rst_o_ovf",   o_ovf,   1'b0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Broadcast: three rd cycles, data two cycles after each request.
        write3();
        @(negedge clk); wr = 1'b0; rd = 1'b1; mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bc_out_k0", out_v, 32'h7654_3210);
        check("bc_val_k0", o_valid, 8'hFF);
        @(negedge clk); rd = 1'b0;
        check("bc_out_k1", out_v, 32'h8765_4321);
        check("bc_val_k1", o_valid, 8'hFF);
        @(negedge clk);
        check("bc_out_k2", out_v, 32'h9876_5432);
        check("bc_val_k2", o_valid, 8'hFF);
        check("bc_empty",  o_empty, 1'b1);
        @(negedge clk);
        check("bc_val_end", o_valid, 8'h00);

        // Diagonal skew: single pulse, one-hot valid walking up the lanes.
        write3();
        @(negedge clk); wr = 1'b0; rd = 1'b1; mode = 1'b1;
        @(negedge clk); rd = 1'b0;
        for (int i = 0; i < nrow; i++) begin
            @(negedge clk);
            check("sk_valid", o_valid, 64'(1) << i);
            check("sk_lane",  out_v[i*nbw +: nbw], nbw'(i));
        end

        // Fill to full, dropped 65th write, then first read returns vector 0.
        do_reset();
        mode = 1'b0;
        for (int n = 0; n < nd; n++) begin
            @(negedge clk); wr = 1'b1; in_v = pat(3 * n);
        end
        @(negedge clk);
        check("full_o_full",  o_full,  1'b1);
        check("full_o_ready", o_ready, 1'b0);
        in_v = pat(200);
        @(negedge clk); wr = 1'b0; rd = 1'b1;
        check("full_o_ovf", o_ovf, ovf_en);
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        check("full_first", out_v, pat(0));
        check("full_after_pop", o_full, 1'b0);

        // Drain to half, then stream wr+rd together across the pointer wrap.
        @(negedge clk); rd = 1'b1;
        repeat (30) @(negedge clk);
        @(negedge clk); rd = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk); wr = 1'b1; rd = 1'b1; in_v = pat(5 * n + 1);
        end
        @(negedge clk); wr = 1'b0;
        check("stream_full",  o_full,  1'b0);
        check("stream_empty", o_empty, 1'b0);

        // Drain and keep reading an empty buffer: out holds the last entry.
        repeat (60) @(negedge clk);
        check("ufl_valid", o_valid, 8'h00);
        check("ufl_empty", o_empty, 1'b1);
        check("ufl_out",   out_v,   pat(5 * 79 + 1));
        rd = 1'b0;

        // Reset while skewed reads are still in flight.
        do_reset();
        write3();
        @(negedge clk); wr = 1'b0; rd = 1'b1; mode = 1'b1;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rr_pre_valid", o_valid, 8'h04);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rr_empty", o_empty, 1'b1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("rr_valid", o_valid, 8'h00);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
